// File: rtl/nios2_cpu_ocimem.sv
// Sysclk-side debug memory controller: JTAG-driven read/write FSM and CPU Avalon port on one RAM.
// Optional OCIMEM_CPU_WRITE_LOCK_EN: CPU writes reach the RAM only while debugack is high.
module nios2_cpu_ocimem #(
  parameter int unsigned RAM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        debugack,
  input  logic [7:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  typedef enum logic [1:0] {StIdle, StRdAddr, StRdCap, StWr} state_e;

  state_e      state_q, state_d;
  logic [7:0]  mon_a_q, mon_a_d;
  logic [31:0] mon_d_q, mon_d_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic        rd_pend_q, rd_pend_d;

  logic        any_strobe;
  logic        jtag_idle;
  logic        cpu_grant;
  logic        cpu_wr_allow;
  logic        unused_bits;

  logic [7:0]  ram_addr;
  logic        ram_rd;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_q;
  logic [31:0] mem [RAM_DEPTH];

  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign jtag_idle  = (state_q == StIdle);
  // The CPU only touches the RAM when the JTAG side can neither be using it nor claim it now.
  assign cpu_grant  = !reset && jtag_idle && !any_strobe;

`ifdef OCIMEM_CPU_WRITE_LOCK_EN
  assign cpu_wr_allow = debugack;
  assign unused_bits  = ^{jdo[37:36], jdo[2:0]};
`else
  assign cpu_wr_allow = 1'b1;
  assign unused_bits  = ^{jdo[37:36], jdo[2:0], debugack};
`endif

  always_comb begin
    state_d   = state_q;
    mon_a_d   = mon_a_q;
    mon_d_d   = mon_d_q;
    wr_data_d = wr_data_q;
    ready_d   = ready_q;
    error_d   = error_q;
    unique case (state_q)
      StIdle: begin
        if (take_action_ocimem_a) begin
          mon_a_d = jdo[33:26];
          ready_d = 1'b0;
          error_d = 1'b0;
          state_d = jdo[35] ? StRdAddr : StIdle;
        end else if (take_no_action_ocimem_a) begin
          mon_a_d = mon_a_q + 8'd1;
          ready_d = 1'b0;
          state_d = StRdAddr;
        end else if (take_action_ocimem_b) begin
          wr_data_d = jdo[34:3];
          ready_d   = 1'b0;
          state_d   = StWr;
        end else begin
          ready_d = 1'b1;
        end
      end
      StRdAddr: state_d = StRdCap;
      StRdCap: begin
        mon_d_d = ram_q;
        ready_d = 1'b1;
        state_d = StIdle;
      end
      StWr: begin
        mon_a_d = mon_a_q + 8'd1;
        ready_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (!jtag_idle && any_strobe) begin
      error_d = 1'b1;
    end
  end

  // First read cycle addresses the RAM; the second presents ram_q with waitrequest low.
  assign rd_pend_d = cpu_grant && read && !rd_pend_q;

  always_comb begin
    if (reset) begin
      waitrequest = read | write;
    end else if (read) begin
      waitrequest = !rd_pend_q;
    end else if (write) begin
      waitrequest = !cpu_grant;
    end else begin
      waitrequest = 1'b0;
    end
  end

  always_comb begin
    ram_addr  = mon_a_q;
    ram_rd    = 1'b0;
    ram_we    = 4'h0;
    ram_wdata = wr_data_q;
    if (state_q == StRdAddr) begin
      ram_rd = 1'b1;
    end else if (state_q == StWr) begin
      ram_we = 4'hF;
    end else if (cpu_grant && read && !rd_pend_q) begin
      ram_addr = address;
      ram_rd   = 1'b1;
    end else if (cpu_grant && write && !read) begin
      ram_addr  = address;
      ram_wdata = writedata;
      ram_we    = cpu_wr_allow ? byteenable : 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i]) begin
        mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_q <= '0;
    end else if (ram_rd) begin
      ram_q <= mem[ram_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mon_a_q   <= 8'h00;
      mon_d_q   <= 32'h0;
      wr_data_q <= 32'h0;
      ready_q   <= 1'b1;
      error_q   <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mon_a_q   <= mon_a_d;
      mon_d_q   <= mon_d_d;
      wr_data_q <= wr_data_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign readdata      = ram_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_nios2_cpu_ocimem.sv
// Randomised scoreboard bench for nios2_cpu_ocimem against a transaction-level memory model.
module tb_nios2_cpu_ocimem;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_a, take_na, take_b;
  logic        debugack;
  logic [7:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  nios2_cpu_ocimem dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_no_action_ocimem_a (take_na),
    .take_action_ocimem_b    (take_b),
    .debugack                (debugack),
    .address                 (address),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .readdata                (readdata),
    .waitrequest             (waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: plain memory array plus the two JTAG registers and the error flag.
  logic [31:0] mem_m [256];
  logic [7:0]  addr_m;
  logic [31:0] dreg_m;
  logic        err_m;

  typedef struct packed {
    logic [31:0] dreg;
    logic        err;
    logic [31:0] due;
  } jexp_t;

  jexp_t       jq[$];
  logic [31:0] cq[$];
  logic        mon_en = 1'b0;
  logic        ready_prev = 1'b1;

  // Monitor: a rising monitor_ready completes one JTAG command; read && !waitrequest one CPU read.
  always @(negedge clk) begin
    if (mon_en) begin
      if (monitor_ready && !ready_prev) begin
        if (jq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL jtag_unexpected_ready: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          check("jtag_MonDReg", MonDReg, jq[0].dreg);
          check("jtag_error", {31'h0, monitor_error}, {31'h0, jq[0].err});
          check("jtag_ready_cycle", cyc, jq[0].due);
          void'(jq.pop_front());
        end
      end
      if (read && !waitrequest) begin
        if (cq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL cpu_unexpected_data: got %h expected none", readdata);
        end else begin
          check("cpu_readdata", readdata, cq[0]);
          void'(cq.pop_front());
        end
      end
    end
    ready_prev <= monitor_ready;
  end

  task automatic wait_jtag_idle();
    for (int i = 0; i < 40; i++) begin
      if (jq.size() == 0) break;
      @(negedge clk);
    end
    n_checks++;
    if (jq.size() != 0) begin
      n_fail++;
      $display("FAIL jtag_timeout: got %0d pending expected 0", jq.size());
      jq.delete();
    end
  endtask

  function automatic logic [37:0] rand_jdo();
    logic [37:0] j;
    j[31:0]  = $urandom;
    j[37:32] = 6'($urandom);
    return j;
  endfunction

  task automatic drop_strobe();
    int r;
    r = $urandom_range(2, 0);
    jdo = rand_jdo();
    take_a  = (r == 0);
    take_na = (r == 1);
    take_b  = (r == 2);
    @(posedge clk); #1;
    take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
  endtask

  // kind 0: load address (optional read), 1: increment+read, 2: write then increment.
  task automatic jtag_op(input int kind, input logic [7:0] a, input logic rd,
                         input logic [31:0] d, input logic losers, input logic collide);
    logic [37:0] j;
    logic [31:0] due;
    wait_jtag_idle();
    @(posedge clk); #1;
    j = rand_jdo();
    if (kind == 0) begin
      j[35] = rd;
      j[33:26] = a;
      take_a = 1'b1;
      if (losers) begin
        take_na = 1'($urandom);
        take_b  = 1'($urandom);
      end
      addr_m = a;
      err_m  = 1'b0;
      if (rd) dreg_m = mem_m[addr_m];
      due = cyc + (rd ? 3 : 2);
    end else if (kind == 1) begin
      take_na = 1'b1;
      if (losers) take_b = 1'($urandom);
      addr_m = addr_m + 8'd1;
      dreg_m = mem_m[addr_m];
      due = cyc + 3;
    end else begin
      j[34:3] = d;
      take_b = 1'b1;
      mem_m[addr_m] = d;
      addr_m = addr_m + 8'd1;
      due = cyc + 2;
    end
    jdo = j;
    if (collide) err_m = 1'b1;
    jq.push_back({dreg_m, err_m, due});
    @(posedge clk); #1;
    take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
    if (collide) drop_strobe();
  endtask

  task automatic cpu_wait(input int exp_wait, input int pre);
    int n;
    n = pre;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!waitrequest) break;
      n++;
    end
    check("cpu_wait_cycles", n, exp_wait);
    @(posedge clk); #1;
    read = 1'b0;
    write = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a);
    wait_jtag_idle();
    @(posedge clk); #1;
    read = 1'b1;
    address = a;
    cq.push_back(mem_m[a]);
    cpu_wait(1, 0);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    logic allow;
    wait_jtag_idle();
    @(posedge clk); #1;
    write = 1'b1;
    address = a;
    writedata = d;
    byteenable = be;
    allow = 1'b1;
`ifdef OCIMEM_CPU_WRITE_LOCK_EN
    allow = debugack;
`endif
    for (int i = 0; i < 4; i++) begin
      if (allow && be[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
    end
    cpu_wait(0, 0);
  endtask

  // JTAG write and CPU read issued in the same cycle; the CPU must wait out the write.
  task automatic jtag_wr_cpu_rd(input logic [31:0] d, input logic [7:0] ca);
    logic [37:0] j;
    int pre;
    wait_jtag_idle();
    @(posedge clk); #1;
    j = rand_jdo();
    j[34:3] = d;
    jdo = j;
    take_b = 1'b1;
    read = 1'b1;
    address = ca;
    mem_m[addr_m] = d;
    addr_m = addr_m + 8'd1;
    jq.push_back({dreg_m, err_m, 32'(cyc + 2)});
    cq.push_back(mem_m[ca]);
    @(negedge clk);
    pre = waitrequest ? 1 : 0;
    @(posedge clk); #1;
    take_b = 1'b0;
    cpu_wait(3, pre);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
    debugack = 1'b1;
    address = '0; read = 1'b0; write = 1'b0; writedata = '0; byteenable = '0;
    addr_m = 8'h00; dreg_m = 32'h0; err_m = 1'b0;

    #12;
    check("rst_MonDReg", MonDReg, 32'h0);
    check("rst_ready", {31'h0, monitor_ready}, 32'h1);
    check("rst_error", {31'h0, monitor_error}, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    check("rst_wait_idle", {31'h0, waitrequest}, 32'h0);
    read = 1'b1; #1;
    check("rst_wait_read", {31'h0, waitrequest}, 32'h1);
    read = 1'b0; write = 1'b1; #1;
    check("rst_wait_write", {31'h0, waitrequest}, 32'h1);
    write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 256; i++) cpu_write(8'(i), $urandom, 4'hF);

    jtag_op(0, 8'h10, 1'b0, 32'h0, 1'b0, 1'b0);
    jtag_op(2, 8'h00, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    jtag_op(0, 8'h10, 1'b1, 32'h0, 1'b0, 1'b0);
    jtag_op(0, 8'hFF, 1'b0, 32'h0, 1'b0, 1'b0);
    jtag_op(1, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0);
    jtag_op(2, 8'h00, 1'b0, 32'hCAFE_0000, 1'b0, 1'b0);
    jtag_op(0, 8'h00, 1'b1, 32'h0, 1'b0, 1'b0);
    jtag_op(0, 8'h33, 1'b1, 32'h0, 1'b0, 1'b1);
    jtag_op(1, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0);
    jtag_op(0, 8'h34, 1'b0, 32'h0, 1'b0, 1'b0);
    jtag_op(2, 8'h00, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b1);
    jtag_op(0, 8'h34, 1'b1, 32'h0, 1'b1, 1'b0);

    jtag_op(0, 8'h20, 1'b0, 32'h0, 1'b0, 1'b0);
    jtag_wr_cpu_rd(32'hA5A5_1234, 8'h20);
    cpu_write(8'h40, 32'hFFFF_FFFF, 4'hF);
    cpu_write(8'h40, 32'h1234_5678, 4'h3);
    cpu_read(8'h40);

    debugack = 1'b0;
    cpu_write(8'h41, 32'h1234_5678, 4'hF);
    cpu_read(8'h41);
    debugack = 1'b1;
    cpu_write(8'h41, 32'h1234_5678, 4'hF);
    cpu_read(8'h41);

    // Reset asserted while the write sits in WR: the RAM must keep its old word.
    jtag_op(0, 8'h55, 1'b0, 32'h0, 1'b0, 1'b0);
    wait_jtag_idle();
    mon_en = 1'b0;
    @(posedge clk); #1;
    jdo = rand_jdo();
    take_b = 1'b1;
    @(posedge clk); #1;
    take_b = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    addr_m = 8'h00; dreg_m = 32'h0; err_m = 1'b0;
    check("abort_MonDReg", MonDReg, 32'h0);
    check("abort_ready", {31'h0, monitor_ready}, 32'h1);
    mon_en = 1'b1;
    jtag_op(0, 8'h55, 1'b1, 32'h0, 1'b0, 1'b0);
    cpu_read(8'h55);

    for (int it = 0; it < 300; it++) begin
      int  k;
      logic rd;
      k = $urandom_range(4, 0);
      rd = 1'($urandom);
      case (k)
        0: jtag_op(0, 8'($urandom), rd, 32'h0, 1'($urandom),
                   rd && ($urandom_range(3, 0) == 0));
        1: jtag_op(1, 8'h00, 1'b0, 32'h0, 1'($urandom), $urandom_range(3, 0) == 0);
        2: jtag_op(2, 8'h00, 1'b0, $urandom, 1'b0, $urandom_range(3, 0) == 0);
        3: cpu_read(8'($urandom));
        default: begin
          debugack = 1'($urandom);
          cpu_write(8'($urandom), $urandom, 4'($urandom));
        end
      endcase
    end

    wait_jtag_idle();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
